// File: rtl/tuser_pkg.sv
// rtl/tuser_pkg.sv - shared state encoding and default widths for the tuser tuple extractor
package tuser_pkg;

    localparam int DEF_DATA_W  = 256;
    localparam int DEF_KEEP_W  = DEF_DATA_W / 8;
    localparam int DEF_TUSER_W = 128;

    localparam logic [2:0] OH_SOP       = 3'b001;
    localparam logic [2:0] OH_BODY      = 3'b010;
    localparam logic [2:0] OH_FULL_WAIT = 3'b100;

    typedef enum logic [2:0] {
        ST_SOP       = OH_SOP,
        ST_BODY      = OH_BODY,
        ST_FULL_WAIT = OH_FULL_WAIT
    } state_t;

endpackage

// File: rtl/tuser_tuple_fifo_fsm_if.sv
// rtl/tuser_tuple_fifo_fsm_if.sv - beat input, beat output and tuple handshake bundle
interface tuser_tuple_fifo_fsm_if #(
    parameter int DATA_W      = 256,
    parameter int TUSER_W     = 128,
    parameter int TUPLE_DEPTH = 4
);
    localparam int KEEP_W  = DATA_W / 8;
    localparam int COUNT_W = $clog2(TUPLE_DEPTH) + 1;

    logic               tin_avalid;
    logic               tin_aready;
    logic [DATA_W-1:0]  tin_adata;
    logic [KEEP_W-1:0]  tin_akeep;
    logic               tin_atlast;
    logic [TUSER_W-1:0] tin_atuser;

    logic               tin_bvalid;
    logic               tin_bready;
    logic [DATA_W-1:0]  tin_bdata;
    logic [KEEP_W-1:0]  tin_bkeep;
    logic               tin_btlast;

    logic               tin_valid;
    logic               tin_ready;
    logic [TUSER_W-1:0] tin_data;
    logic [COUNT_W-1:0] tin_count;

    modport master (
        input  tin_avalid, tin_adata, tin_akeep, tin_atlast, tin_atuser,
        output tin_aready,
        output tin_bvalid, tin_bdata, tin_bkeep, tin_btlast,
        input  tin_bready,
        output tin_valid, tin_data, tin_count,
        input  tin_ready
    );

    modport slave (
        output tin_avalid, tin_adata, tin_akeep, tin_atlast, tin_atuser,
        input  tin_aready,
        input  tin_bvalid, tin_bdata, tin_bkeep, tin_btlast,
        output tin_bready,
        input  tin_valid, tin_data, tin_count,
        output tin_ready
    );

endinterface

// File: rtl/tuple_fifo.sv
// rtl/tuple_fifo.sv - synchronous FIFO holding one metadata tuple per packet
module tuple_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Head reads as zero when empty so stale entries never leak after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tuser_tuple_fifo_fsm.sv
// rtl/tuser_tuple_fifo_fsm.sv - beat register slice plus per-packet tuser tuple FIFO; TUSER_TUPLE_STATS_EN adds counters
module tuser_tuple_fifo_fsm
    import tuser_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TUSER_W     = DEF_TUSER_W,
    parameter int TUPLE_DEPTH = 4
) (
    input  logic                    tin_aclk,
    input  logic                    tin_arstn,
    tuser_tuple_fifo_fsm_if.master  bus,
    output logic [2:0]              dbg_state
`ifdef TUSER_TUPLE_STATS_EN
    ,
    output logic [31:0]             stat_pkts,
    output logic [31:0]             stat_stalls
`endif
);
    localparam int KEEP_W = DATA_W / 8;

    state_t             state;
    state_t             state_nxt;
    logic               bvalid_q;
    logic [DATA_W-1:0]  bdata_q;
    logic [KEEP_W-1:0]  bkeep_q;
    logic               btlast_q;
    logic               aready;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;

    // full is the registered occupancy flag; a same-cycle pop does not reopen the input.
    assign aready = tin_arstn
                 && (!bvalid_q || bus.tin_bready)
                 && !((state == ST_SOP) && fifo_full)
                 && (state != ST_FULL_WAIT);
    assign accept = bus.tin_avalid && aready;
    assign push   = accept && (state == ST_SOP);
    assign pop    = bus.tin_ready && !fifo_empty;

    always_ff @(posedge tin_aclk) begin
        if (!tin_arstn) begin
            state <= ST_SOP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SOP: begin
                if (accept) begin
                    state_nxt = bus.tin_atlast ? ST_SOP : ST_BODY;
                end else if (bus.tin_avalid && fifo_full) begin
                    state_nxt = ST_FULL_WAIT;
                end
            end
            ST_BODY: begin
                if (accept && bus.tin_atlast) begin
                    state_nxt = ST_SOP;
                end
            end
            ST_FULL_WAIT: begin
                if (!fifo_full) begin
                    state_nxt = ST_SOP;
                end
            end
            default: state_nxt = ST_SOP;
        endcase
    end

    always_ff @(posedge tin_aclk) begin
        if (!tin_arstn) begin
            bvalid_q <= 1'b0;
            bdata_q  <= '0;
            bkeep_q  <= '0;
            btlast_q <= 1'b0;
        end else if (accept) begin
            bvalid_q <= 1'b1;
            bdata_q  <= bus.tin_adata;
            bkeep_q  <= bus.tin_akeep;
            btlast_q <= bus.tin_atlast;
        end else if (bus.tin_bready) begin
            bvalid_q <= 1'b0;
        end
    end

    tuple_fifo #(
        .W     (TUSER_W),
        .DEPTH (TUPLE_DEPTH)
    ) u_tuple_fifo (
        .clk       (tin_aclk),
        .resetn    (tin_arstn),
        .push      (push),
        .push_data (bus.tin_atuser),
        .pop       (pop),
        .pop_data  (bus.tin_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (bus.tin_count)
    );

    assign bus.tin_aready = aready;
    assign bus.tin_bvalid = bvalid_q;
    assign bus.tin_bdata  = bdata_q;
    assign bus.tin_bkeep  = bkeep_q;
    assign bus.tin_btlast = btlast_q;
    assign bus.tin_valid  = !fifo_empty;
    assign dbg_state      = state;

`ifdef TUSER_TUPLE_STATS_EN
    always_ff @(posedge tin_aclk) begin
        if (!tin_arstn) begin
            stat_pkts   <= '0;
            stat_stalls <= '0;
        end else begin
            if (push) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if (state == ST_FULL_WAIT) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tuser_tuple_fifo_fsm.sv
// tb/tb_tuser_tuple_fifo_fsm.sv - directed bench for tuser_tuple_fifo_fsm
module tb_tuser_tuple_fifo_fsm;
    localparam int DATA_W      = 256;
    localparam int TUSER_W     = 128;
    localparam int TUPLE_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  dbg_state;
`ifdef TUSER_TUPLE_STATS_EN
    logic [31:0] stat_pkts;
    logic [31:0] stat_stalls;
`endif

    int checks = 0;
    int errors = 0;

    tuser_tuple_fifo_fsm_if #(
        .DATA_W(DATA_W), .TUSER_W(TUSER_W), .TUPLE_DEPTH(TUPLE_DEPTH)
    ) bus ();

    tuser_tuple_fifo_fsm #(
        .DATA_W(DATA_W), .TUSER_W(TUSER_W), .TUPLE_DEPTH(TUPLE_DEPTH)
    ) dut (
        .tin_aclk  (clk),
        .tin_arstn (rstn),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef TUSER_TUPLE_STATS_EN
        ,
        .stat_pkts   (stat_pkts),
        .stat_stalls (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [255:0] d, input logic [127:0] u, input logic last);
        bus.tin_avalid = 1'b1;
        bus.tin_adata  = d;
        bus.tin_akeep  = 32'h33333;
        bus.tin_atuser = u;
        bus.tin_atlast = last;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.tin_avalid = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    int          sent;
    int          got;
    logic        bready_tgl;
    logic        p_ar;
    logic        p_bv;
    logic [255:0] p_bd;

    initial begin
        bus.tin_avalid = 1'b0;
        bus.tin_adata  = '0;
        bus.tin_akeep  = '0;
        bus.tin_atlast = 1'b0;
        bus.tin_atuser = '0;
        bus.tin_bready = 1'b1;
        bus.tin_ready  = 1'b1;

        // reset values
        step();
        step();
        chk("rst_aready", bus.tin_aready, 1'b0);
        chk("rst_bvalid", bus.tin_bvalid, 1'b0);
        chk("rst_bdata", bus.tin_bdata, '0);
        chk("rst_bkeep", bus.tin_bkeep, '0);
        chk("rst_btlast", bus.tin_btlast, 1'b0);
        chk("rst_valid", bus.tin_valid, 1'b0);
        chk("rst_data", bus.tin_data, '0);
        chk("rst_count", bus.tin_count, '0);
        chk("rst_state", dbg_state, 3'b001);
        rstn = 1'b1;
        #1;
        chk("post_rst_aready", bus.tin_aready, 1'b1);

        // 3-beat packet, everything ready
        beat(256'h22222, 128'h44444, 1'b0);
        step();
        chk("p1_b1_bvalid", bus.tin_bvalid, 1'b1);
        chk("p1_b1_bdata", bus.tin_bdata, 256'h22222);
        chk("p1_b1_bkeep", bus.tin_bkeep, 32'h33333);
        chk("p1_b1_btlast", bus.tin_btlast, 1'b0);
        chk("p1_tuple_valid", bus.tin_valid, 1'b1);
        chk("p1_tuple_data", bus.tin_data, 128'h44444);
        chk("p1_count1", bus.tin_count, 3'd1);
        chk("p1_state_body", dbg_state, 3'b010);
        beat(256'h22222, 128'h44444, 1'b0);
        step();
        chk("p1_b2_bvalid", bus.tin_bvalid, 1'b1);
        chk("p1_b2_btlast", bus.tin_btlast, 1'b0);
        chk("p1_count0", bus.tin_count, 3'd0);
        beat(256'h22222, 128'h44444, 1'b1);
        step();
        chk("p1_b3_bdata", bus.tin_bdata, 256'h22222);
        chk("p1_b3_btlast", bus.tin_btlast, 1'b1);
        chk("p1_state_sop", dbg_state, 3'b001);
        chk("p1_no_extra_tuple", bus.tin_count, 3'd0);
        bus.tin_avalid = 1'b0;
        step();
        chk("p1_idle_bvalid", bus.tin_bvalid, 1'b0);

        // single-beat packet
        bus.tin_ready = 1'b0;
        beat(256'h1, 128'h55, 1'b1);
        step();
        chk("p2_state_sop", dbg_state, 3'b001);
        chk("p2_count", bus.tin_count, 3'd1);
        chk("p2_tuple", bus.tin_data, 128'h55);
        bus.tin_avalid = 1'b0;
        bus.tin_ready  = 1'b1;
        step();
        chk("p2_popped", bus.tin_count, 3'd0);

        // tuple consumer stalled across five 2-beat packets
        bus.tin_ready = 1'b0;
        do_reset();
        for (int p = 1; p <= 4; p++) begin
            beat(256'(p), 128'(32'h100 + p), 1'b0);
            step();
            beat(256'(p), 128'h0, 1'b1);
            step();
        end
        chk("p3_count4", bus.tin_count, 3'd4);
        chk("p3_sop_full_aready", bus.tin_aready, 1'b0);
        chk("p3_head", bus.tin_data, 128'h101);
        beat(256'h5, 128'h105, 1'b0);
        step();
        chk("p3_full_wait", dbg_state, 3'b100);
        chk("p3_fw_aready", bus.tin_aready, 1'b0);
        step();
        chk("p3_fw_hold", dbg_state, 3'b100);
        chk("p3_head_stable", bus.tin_data, 128'h101);
        bus.tin_ready = 1'b1;
        step();
        bus.tin_ready = 1'b0;
        chk("p3_one_pop", bus.tin_count, 3'd3);
        chk("p3_new_head", bus.tin_data, 128'h102);
        chk("p3_fw_after_pop", dbg_state, 3'b100);
        step();
        chk("p3_back_sop", dbg_state, 3'b001);
        chk("p3_sop_aready", bus.tin_aready, 1'b1);
        step();
        chk("p3_p5_pushed", bus.tin_count, 3'd4);
        chk("p3_p5_body", dbg_state, 3'b010);
        beat(256'h5, 128'h0, 1'b1);
        step();
        bus.tin_avalid = 1'b0;
        chk("p3_p5_done", dbg_state, 3'b001);
`ifdef TUSER_TUPLE_STATS_EN
        chk("stat_pkts", stat_pkts, 32'd5);
        chk("stat_stalls", stat_stalls, 32'd3);
`endif
        bus.tin_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("p3_order_%0d", i), bus.tin_data, 128'(32'h100 + i));
            step();
        end
        chk("p3_drained", bus.tin_count, 3'd0);

        // output backpressure toggling every cycle over a 4-beat packet
        sent = 0;
        got = 0;
        bready_tgl = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            bus.tin_avalid = (sent < 4);
            bus.tin_adata  = 256'(32'hA0 + sent);
            bus.tin_atuser = 128'hC0;
            bus.tin_atlast = (sent == 3);
            bus.tin_bready = bready_tgl;
            @(negedge clk);
            p_ar = bus.tin_aready;
            p_bv = bus.tin_bvalid;
            p_bd = bus.tin_bdata;
            @(posedge clk);
            #1;
            if (p_ar && sent < 4) sent++;
            if (p_bv && bready_tgl) begin
                chk($sformatf("p4_beat_%0d", got), p_bd, 256'(32'hA0 + got));
                got++;
            end else if (p_bv) begin
                chk("p4_hold_stable", bus.tin_bdata, p_bd);
            end
            bready_tgl = !bready_tgl;
        end
        bus.tin_avalid = 1'b0;
        bus.tin_bready = 1'b1;
        chk("p4_all_beats", 32'(got), 32'd4);
        step();
        chk("p4_bvalid_idle", bus.tin_bvalid, 1'b0);

        // reset on beat 2 of a 4-beat packet
        bus.tin_ready = 1'b0;
        beat(256'h1, 128'h99, 1'b0);
        step();
        chk("p5_pre_count", bus.tin_count, 3'd1);
        beat(256'h2, 128'h0, 1'b0);
        rstn = 1'b0;
        step();
        chk("p5_rst_bvalid", bus.tin_bvalid, 1'b0);
        chk("p5_rst_bdata", bus.tin_bdata, '0);
        chk("p5_rst_valid", bus.tin_valid, 1'b0);
        chk("p5_rst_data", bus.tin_data, '0);
        chk("p5_rst_count", bus.tin_count, '0);
        chk("p5_rst_state", dbg_state, 3'b001);
        chk("p5_rst_aready", bus.tin_aready, 1'b0);
        rstn = 1'b1;
        beat(256'h3, 128'h7, 1'b0);
        step();
        beat(256'h4, 128'h8, 1'b1);
        step();
        bus.tin_avalid = 1'b0;
        chk("p5_one_tuple", bus.tin_count, 3'd1);
        chk("p5_tuple7", bus.tin_data, 128'h7);
        bus.tin_ready = 1'b1;
        step();
        chk("p5_empty", bus.tin_count, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tuser_tuple_fifo_fsm.md
# tuser_tuple_fifo_fsm

Parametrised successor to the packet-metadata extractor between the AXIS ingress and the P4/SDNet tuple engine. Forwards AXI4-Stream beats unchanged through a one-stage register slice. On the first beat of every packet it captures `tuser` into a tuple FIFO. The tuple side has its own valid/ready handshake, so the tuple consumer can lag the data path by up to `TUPLE_DEPTH` packets.

## Interface
Parameters:
- `DATA_W`, 256, tdata width; multiple of 8.
- `KEEP_W`, `DATA_W/8`, tkeep width; derived, not overridable.
- `TUSER_W`, 128, tuser/tuple width.
- `TUPLE_DEPTH`, 4, tuple FIFO entries; power of two, ≥2.

Ports:
- `tin_aclk`  in  1  clock; all logic rising-edge.
- `tin_arstn`  in  1  reset; **synchronous, active-low**.
- `tin_avalid` / `tin_aready`  in / out  1  input beat handshake.
- `tin_adata`  in  DATA_W  input data.
- `tin_akeep`  in  KEEP_W  input byte enables.
- `tin_atlast`  in  1  input end of packet.
- `tin_atuser`  in  TUSER_W  metadata; sampled on first beat only.
- `tin_bvalid` / `tin_bready`  out / in  1  output beat handshake.
- `tin_bdata`, `tin_bkeep`, `tin_btlast`  out  DATA_W, KEEP_W, 1  registered copies of the input beat.
- `tin_valid` / `tin_ready`  out / in  1  tuple handshake.
- `tin_data`  out  TUSER_W  FIFO head tuple.
- `tin_count`  out  $clog2(TUPLE_DEPTH)+1  FIFO occupancy.
- `dbg_state`  out  3  one-hot FSM state: bit0 SOP, bit1 BODY, bit2 FULL_WAIT.

## Operation
- FSM, next state evaluated each clock:
  - **SOP** (reset state): waits for first beat.
    - Beat accepted with `tin_atlast`=0 → BODY.
    - Beat accepted with `tin_atlast`=1 → stays SOP (single-beat packet).
    - `tin_avalid`=1 and FIFO full → FULL_WAIT.
  - **BODY**: beats pass through with no tuple push. Accepted beat with tlast → SOP.
  - **FULL_WAIT**: `tin_aready`=0. Moves to SOP on the cycle after the FIFO becomes not-full.
- Beat acceptance (`tin_avalid && tin_aready`):
  - Loads the output slice.
  - In SOP, also pushes `tin_atuser`.
- `tin_aready` = (!`tin_bvalid` || `tin_bready`) && !(SOP && full) && !FULL_WAIT.
  - `full` is the registered FIFO flag; a pop in the same cycle does not bypass it.
- FIFO:
  - Pop on `tin_valid && tin_ready`.
  - `tin_valid` = count≠0.
  - Simultaneous push and pop: count unchanged.
  - Read/write pointers wrap modulo TUPLE_DEPTH; count saturates at TUPLE_DEPTH by construction.
- No data modification: tdata, tkeep, tlast bit-exact. tkeep is not checked.
- Reset mid-packet:
  - Slice and FIFO empty, FSM to SOP, partial packet discarded.
  - The next accepted beat is treated as SOP.

## Timing
- Reset values:
  - `tin_aready`=0 during reset, 1 the first cycle after.
  - `tin_bvalid`=0, `tin_bdata`/`tin_bkeep`/`tin_btlast`=0.
  - `tin_valid`=0, `tin_data`=0, `tin_count`=0, `dbg_state`=3'b001.
- Data latency: 1 cycle, accept at edge N → `tin_bvalid` after edge N. Full throughput with `tin_bready` held high.
- Tuple latency: 1 cycle. The tuple is at the FIFO head alongside the first output beat of its packet.
- Output slice holds its data stable while `tin_bvalid && !tin_bready`.
- `tin_data` is stable while `tin_valid && !tin_ready`.

## Configuration
- `TUSER_TUPLE_STATS_EN` defined: adds these outputs:
  - `stat_pkts` (32 b): increments per tuple pushed.
  - `stat_stalls` (32 b): increments each cycle in FULL_WAIT.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `tuser_pkg`:
  - State enum and one-hot encoding constants.
  - Default width constants (256/32/128).
- Sub-module `tuple_fifo`: synchronous FIFO parametrised by width/depth, with push/pop/full/empty/count.
- FSM and output slice stay in the top module.

## Test plan
- Reset, then one 3-beat packet (tuser=44444, tdata=22222, tkeep=33333), all ready high:
  - three output beats one cycle later, identical, tlast on beat 3;
  - one tuple 44444; `tin_count` returns to 0.
- Single-beat packet (tlast on first beat):
  - tuple pushed; `dbg_state` stays 3'b001.
- `tin_ready`=0, five 2-beat packets, TUPLE_DEPTH=4:
  - four tuples stored, `tin_count`=4;
  - fifth SOP → FULL_WAIT, `tin_aready`=0.
  - Raising `tin_ready` one cycle → one pop; fifth packet accepted on the following cycles; tuples emerge in order.
- `tin_bready` toggling 1/0 every cycle over a 4-beat packet:
  - no beat lost or duplicated; output held stable while stalled.
- Assert `tin_arstn`=0 on beat 2 of a 4-beat packet:
  - all outputs return to reset values next cycle;
  - a new packet with tuser=7 yields exactly one tuple 7.
- With `TUSER_TUPLE_STATS_EN`, run the full-FIFO scenario:
  - `stat_pkts`=5 and `stat_stalls` equals the cycles spent in FULL_WAIT.
